// File: rtl/mod_n_counter.sv
// Parametrised modulo-N counter with enable, clamped parallel load, terminal count and wrap pulse.
// Define MOD_N_COUNTER_UPDOWN_EN to honour the up input; otherwise the counter is up-only.
module mod_n_counter #(
    parameter int MODULUS = 14,
    parameter int WIDTH   = $clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             dir_up;

`ifdef MOD_N_COUNTER_UPDOWN_EN
    assign dir_up = up;
`else
    logic unused_up;
    assign unused_up = up;
    assign dir_up    = 1'b1;
`endif

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            // Out-of-range loads clamp to the top count rather than aliasing.
            if (load_val <= MAX) begin
                q_d = load_val;
            end else begin
                q_d   = MAX;
                err_d = 1'b1;
            end
        end else if (en) begin
            if (dir_up) begin
                if (q_q == MAX) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end
`ifdef MOD_N_COUNTER_UPDOWN_EN
            else begin
                if (q_q == '0) begin
                    q_d    = MAX;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    // Combinational so a following digit can use it directly as its enable.
    assign tc       = en & (dir_up ? (q_q == MAX) : (q_q == '0));
    assign q        = q_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed self-checking bench for mod_n_counter: mod-14 main instance, power-of-two and
// mod-2 instances, a two-digit decimal cascade, and (when enabled) an up/down mod-10 instance.
module tb_mod_n_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // mod-14 main instance
    logic       rst_a = 1'b1, en_a = 1'b0, ld_a = 1'b0, up_a = 1'b1;
    logic [3:0] lv_a = '0, q_a;
    logic       tc_a, wr_a, er_a;
    mod_n_counter #(.MODULUS(14)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .load(ld_a), .load_val(lv_a), .up(up_a),
        .q(q_a), .tc(tc_a), .wrap(wr_a), .load_err(er_a));

    // mod-16 and mod-2 instances sharing controls
    logic       rst_b = 1'b1, en_b = 1'b0;
    logic [3:0] q16;
    logic       q2;
    logic       tc16, wr16, er16, tc2, wr2, er2;
    mod_n_counter #(.MODULUS(16)) u_16 (
        .clk(clk), .rst(rst_b), .en(en_b), .load(1'b0), .load_val(4'd0), .up(1'b1),
        .q(q16), .tc(tc16), .wrap(wr16), .load_err(er16));
    mod_n_counter #(.MODULUS(2)) u_2 (
        .clk(clk), .rst(rst_b), .en(en_b), .load(1'b0), .load_val(1'b0), .up(1'b1),
        .q(q2), .tc(tc2), .wrap(wr2), .load_err(er2));

    // two-digit decimal cascade
    logic       rst_c = 1'b1, en_c = 1'b0;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, wr_lo, wr_hi, er_lo, er_hi;
    mod_n_counter #(.MODULUS(10)) u_lo (
        .clk(clk), .rst(rst_c), .en(en_c), .load(1'b0), .load_val(4'd0), .up(1'b1),
        .q(q_lo), .tc(tc_lo), .wrap(wr_lo), .load_err(er_lo));
    mod_n_counter #(.MODULUS(10)) u_hi (
        .clk(clk), .rst(rst_c), .en(tc_lo), .load(1'b0), .load_val(4'd0), .up(1'b1),
        .q(q_hi), .tc(tc_hi), .wrap(wr_hi), .load_err(er_hi));

    // mod-10 up/down instance
    logic       rst_d = 1'b1, en_d = 1'b0, ld_d = 1'b0, up_d = 1'b1;
    logic [3:0] lv_d = '0, q_d;
    logic       tc_d, wr_d, er_d;
    mod_n_counter #(.MODULUS(10)) u_d (
        .clk(clk), .rst(rst_d), .en(en_d), .load(ld_d), .load_val(lv_d), .up(up_d),
        .q(q_d), .tc(tc_d), .wrap(wr_d), .load_err(er_d));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b0; ld_a = 1'b0;
        step(); step();
        n_cmp++; if (q_a !== 4'd0) begin n_bad++; $display("FAIL reset_q got %0d exp 0", q_a); end
        n_cmp++; if (wr_a !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b exp 0", wr_a); end
        n_cmp++; if (er_a !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", er_a); end
        en_a = 1'b1; #1;
        n_cmp++; if (tc_a !== 1'b0) begin n_bad++; $display("FAIL reset_tc got %b exp 0", tc_a); end
        en_a = 1'b0;
    endtask

    task automatic test_count();
        rst_a = 1'b0; en_a = 1'b1; #1;
        for (int k = 1; k <= 30; k++) begin
            n_cmp++;
            if (tc_a !== (((k - 1) % 14) == 13)) begin
                n_bad++; $display("FAIL count_tc k=%0d got %b exp %b", k, tc_a, ((k - 1) % 14) == 13);
            end
            step();
            n_cmp++;
            if (q_a !== 4'(k % 14)) begin
                n_bad++; $display("FAIL count_q k=%0d got %0d exp %0d", k, q_a, k % 14);
            end
            n_cmp++;
            if (wr_a !== ((k % 14) == 0)) begin
                n_bad++; $display("FAIL count_wrap k=%0d got %b exp %b", k, wr_a, (k % 14) == 0);
            end
        end
    endtask

    task automatic test_hold_reset();
        // q is 2 here; advance to 7, then hold
        for (int k = 0; k < 5; k++) step();
        en_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++; if (q_a !== 4'd7) begin n_bad++; $display("FAIL hold_q got %0d exp 7", q_a); end
            n_cmp++; if (wr_a !== 1'b0) begin n_bad++; $display("FAIL hold_wrap got %b exp 0", wr_a); end
        end
        rst_a = 1'b1; step(); rst_a = 1'b0;
        n_cmp++; if (q_a !== 4'd0) begin n_bad++; $display("FAIL midrst_q got %0d exp 0", q_a); end
        n_cmp++; if (er_a !== 1'b0) begin n_bad++; $display("FAIL midrst_err got %b exp 0", er_a); end
        // reset beats a pending wrap and a load
        ld_a = 1'b1; lv_a = 4'd13; step(); ld_a = 1'b0;
        rst_a = 1'b1; en_a = 1'b1; ld_a = 1'b1; lv_a = 4'd5; step();
        rst_a = 1'b0; en_a = 1'b0; ld_a = 1'b0;
        n_cmp++; if (q_a !== 4'd0) begin n_bad++; $display("FAIL rstwin_q got %0d exp 0", q_a); end
        n_cmp++; if (wr_a !== 1'b0) begin n_bad++; $display("FAIL rstwin_wrap got %b exp 0", wr_a); end
    endtask

    task automatic test_load();
        ld_a = 1'b1; lv_a = 4'd9; step();
        n_cmp++; if (q_a !== 4'd9) begin n_bad++; $display("FAIL load9_q got %0d exp 9", q_a); end
        n_cmp++; if (er_a !== 1'b0) begin n_bad++; $display("FAIL load9_err got %b exp 0", er_a); end
        lv_a = 4'd15; step();
        n_cmp++; if (q_a !== 4'd13) begin n_bad++; $display("FAIL load15_q got %0d exp 13", q_a); end
        n_cmp++; if (er_a !== 1'b1) begin n_bad++; $display("FAIL load15_err got %b exp 1", er_a); end
        ld_a = 1'b0; step();
        n_cmp++; if (q_a !== 4'd13) begin n_bad++; $display("FAIL loadhold_q got %0d exp 13", q_a); end
        n_cmp++; if (er_a !== 1'b0) begin n_bad++; $display("FAIL err_pulse got %b exp 0", er_a); end
        ld_a = 1'b1; lv_a = 4'd14; step();
        n_cmp++; if (q_a !== 4'd13) begin n_bad++; $display("FAIL load14_q got %0d exp 13", q_a); end
        n_cmp++; if (er_a !== 1'b1) begin n_bad++; $display("FAIL load14_err got %b exp 1", er_a); end
        lv_a = 4'd13; step();
        n_cmp++; if (er_a !== 1'b0) begin n_bad++; $display("FAIL load13_err got %b exp 0", er_a); end
        // load and wrap condition together: tc still shows, load wins
        lv_a = 4'd4; en_a = 1'b1; #1;
        n_cmp++; if (tc_a !== 1'b1) begin n_bad++; $display("FAIL loadtc got %b exp 1", tc_a); end
        step();
        n_cmp++; if (q_a !== 4'd4) begin n_bad++; $display("FAIL loadwin_q got %0d exp 4", q_a); end
        n_cmp++; if (wr_a !== 1'b0) begin n_bad++; $display("FAIL loadwin_wrap got %b exp 0", wr_a); end
        ld_a = 1'b0; en_a = 1'b0;
    endtask

    task automatic test_direction();
`ifdef MOD_N_COUNTER_UPDOWN_EN
        rst_d = 1'b0; ld_d = 1'b1; lv_d = 4'd2; step(); ld_d = 1'b0;
        up_d = 1'b0; en_d = 1'b1; #1;
        n_cmp++; if (tc_d !== 1'b0) begin n_bad++; $display("FAIL dn_tc2 got %b exp 0", tc_d); end
        step();
        n_cmp++; if (q_d !== 4'd1) begin n_bad++; $display("FAIL dn_q1 got %0d exp 1", q_d); end
        step();
        n_cmp++; if (q_d !== 4'd0) begin n_bad++; $display("FAIL dn_q0 got %0d exp 0", q_d); end
        n_cmp++; if (tc_d !== 1'b1) begin n_bad++; $display("FAIL dn_tc0 got %b exp 1", tc_d); end
        step();
        n_cmp++; if (q_d !== 4'd9) begin n_bad++; $display("FAIL dn_q9 got %0d exp 9", q_d); end
        n_cmp++; if (wr_d !== 1'b1) begin n_bad++; $display("FAIL dn_wrap got %b exp 1", wr_d); end
        step();
        n_cmp++; if (q_d !== 4'd8) begin n_bad++; $display("FAIL dn_q8 got %0d exp 8", q_d); end
        n_cmp++; if (wr_d !== 1'b0) begin n_bad++; $display("FAIL dn_wrap8 got %b exp 0", wr_d); end
        up_d = 1'b1; step();
        n_cmp++; if (q_d !== 4'd9) begin n_bad++; $display("FAIL upd_q9 got %0d exp 9", q_d); end
        n_cmp++; if (tc_d !== 1'b1) begin n_bad++; $display("FAIL upd_tc9 got %b exp 1", tc_d); end
        step();
        n_cmp++; if (q_d !== 4'd0) begin n_bad++; $display("FAIL upd_q0 got %0d exp 0", q_d); end
        n_cmp++; if (wr_d !== 1'b1) begin n_bad++; $display("FAIL upd_wrap got %b exp 1", wr_d); end
        en_d = 1'b0;
`else
        // up is ignored: counting stays upward even with up=0, and tc tracks q==13
        up_a = 1'b0; en_a = 1'b1; #1;
        n_cmp++; if (tc_a !== 1'b0) begin n_bad++; $display("FAIL noupd_tc got %b exp 0", tc_a); end
        step();
        n_cmp++; if (q_a !== 4'd5) begin n_bad++; $display("FAIL noupd_q got %0d exp 5", q_a); end
        ld_a = 1'b1; lv_a = 4'd0; step(); ld_a = 1'b0; #1;
        n_cmp++; if (tc_a !== 1'b0) begin n_bad++; $display("FAIL noupd_tc0 got %b exp 0", tc_a); end
        step();
        n_cmp++; if (q_a !== 4'd1) begin n_bad++; $display("FAIL noupd_q1 got %0d exp 1", q_a); end
        en_a = 1'b0; up_a = 1'b1;
`endif
    endtask

    task automatic test_pow2();
        rst_b = 1'b0; en_b = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++; if (q16 !== 4'(k % 16)) begin n_bad++; $display("FAIL m16_q k=%0d got %0d exp %0d", k, q16, k % 16); end
            n_cmp++; if (wr16 !== ((k % 16) == 0)) begin n_bad++; $display("FAIL m16_wrap k=%0d got %b", k, wr16); end
            n_cmp++; if (q2 !== 1'(k % 2)) begin n_bad++; $display("FAIL m2_q k=%0d got %0d exp %0d", k, q2, k % 2); end
            n_cmp++; if (wr2 !== ((k % 2) == 0)) begin n_bad++; $display("FAIL m2_wrap k=%0d got %b", k, wr2); end
        end
        en_b = 1'b0;
    endtask

    task automatic test_cascade();
        int wraps;
        wraps = 0;
        rst_c = 1'b0; en_c = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (wr_hi === 1'b1) wraps++;
            if (k == 55) begin
                n_cmp++; if (q_lo !== 4'd5 || q_hi !== 4'd5) begin n_bad++; $display("FAIL casc55 got %0d%0d exp 55", q_hi, q_lo); end
            end
            if (k == 99) begin
                n_cmp++; if (tc_hi !== 1'b1) begin n_bad++; $display("FAIL casc_tc_hi got %b exp 1", tc_hi); end
            end
        end
        n_cmp++; if (q_lo !== 4'd0) begin n_bad++; $display("FAIL casc_lo got %0d exp 0", q_lo); end
        n_cmp++; if (q_hi !== 4'd0) begin n_bad++; $display("FAIL casc_hi got %0d exp 0", q_hi); end
        n_cmp++; if (wraps !== 1) begin n_bad++; $display("FAIL casc_wraps got %0d exp 1", wraps); end
        n_cmp++; if (wr_hi !== 1'b1) begin n_bad++; $display("FAIL casc_wrap_last got %b exp 1", wr_hi); end
        en_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count();
        test_hold_reset();
        test_load();
        test_direction();
        test_pow2();
        test_cascade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
